// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer: one 32-bit carry-skip adder reused for each word,
// least significant word first, with valid/ready handshakes on the operand and result sides.
module wide_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [WORDS-1:0][31:0]  a_q;
    logic [WORDS-1:0][31:0]  b_q;
    logic                    sub_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    carry_q;
    logic [WORDS-1:0][31:0]  sum_q;
    logic                    cout_q;

    logic [31:0]             add_a;
    logic [31:0]             add_b;
    logic [31:0]             add_sum;
    logic                    add_cout;

    // 4-bit slice: ripple internally, but the carry-out bypasses the ripple when
    // every bit propagates, so the slice-to-slice path is a single mux.
    function automatic logic [4:0] cs_slice4(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] s;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]   = p[i] ^ c[i];
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {((&p) ? ci : c[4]), s};
    endfunction

    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q] ^ {32{sub_q}};

    always_comb begin
        logic [8:0] chain;
        logic [4:0] slice_res;
        chain     = '0;
        chain[0]  = carry_q;
        add_sum   = '0;
        slice_res = '0;
        for (int unsigned s = 0; s < 8; s++) begin
            slice_res          = cs_slice4(add_a[4*s +: 4], add_b[4*s +: 4], chain[s]);
            add_sum[4*s +: 4]  = slice_res[3:0];
            chain[s+1]         = slice_res[4];
        end
        add_cout = chain[8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        sub_q      <= sub;
                        idx_q      <= '0;
                        carry_q    <= sub;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    // idx saturates at the last word instead of wrapping
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= add_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq: a WORDS=4 instance driven from a vector table plus
// hand-written backpressure and mid-run reset sequences, and a WORDS=1 instance.
module tb_wide_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic          sub;
    logic [127:0]  a;
    logic [127:0]  b;
    logic          in_ready;
    logic          out_valid;
    logic [127:0]  sum;
    logic          cout;

    logic          in_valid1;
    logic          out_ready1;
    logic          sub1;
    logic [31:0]   a1;
    logic [31:0]   b1;
    logic          in_ready1;
    logic          out_valid1;
    logic [31:0]   sum1;
    logic          cout1;

    wide_add_seq #(.WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    wide_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Starts and ends on a falling edge; the rising edge in between is the acceptance edge.
    task automatic accept(input logic [127:0] av, input logic [127:0] bv, input logic s);
        a        = av;
        b        = bv;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int unsigned lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         sub;
        logic [127:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned lat;
        logic [127:0] held_sum;

        vecs[0] = '{{128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1};
        vecs[1] = '{128'd0, 128'd1, 1'b1, {128{1'b1}}, 1'b0};
        vecs[2] = '{128'd5, 128'd5, 1'b1, 128'd0, 1'b1};
        vecs[3] = '{128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0,
                    128'h00000000_00000000_00000001_00000000, 1'b0};
        vecs[4] = '{128'd7, 128'd3, 1'b1, 128'd4, 1'b1};
        vecs[5] = '{128'd3, 128'd7, 1'b1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFC, 1'b0};
        vecs[6] = '{128'h80000000_00000000_00000000_00000000,
                    128'h80000000_00000000_00000000_00000000, 1'b0, 128'd0, 1'b1};
        vecs[7] = '{128'h00000001_00000000_00000000_00000000, 128'd1, 1'b1,
                    128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset sum", sum, 128'd0);
        check("reset cout", 128'(cout), 128'd0);
        check("reset w1 in_ready", 128'(in_ready1), 128'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].sub);
            check($sformatf("vec%0d in_ready busy", i), 128'(in_ready), 128'd0);
            wait_done(lat);
            check($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
            check($sformatf("vec%0d sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d cout", i), 128'(cout), 128'(vecs[i].cout));
            release_result();
            check($sformatf("vec%0d idle in_ready", i), 128'(in_ready), 128'd1);
            check($sformatf("vec%0d idle out_valid", i), 128'(out_valid), 128'd0);
        end

        // Backpressure: result 10+20 held while a new request waits.
        accept(128'd10, 128'd20, 1'b0);
        wait_done(lat);
        check("bp sum", sum, 128'd30);
        held_sum = sum;
        a = 128'd100;
        b = 128'd1;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold%0d sum", c), sum, held_sum);
            check($sformatf("bp hold%0d cout", c), 128'(cout), 128'd0);
            check($sformatf("bp hold%0d in_ready", c), 128'(in_ready), 128'd0);
            check($sformatf("bp hold%0d out_valid", c), 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp back idle in_ready", 128'(in_ready), 128'd1);
        check("bp back idle out_valid", 128'(out_valid), 128'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp accepted in_ready", 128'(in_ready), 128'd0);
        wait_done(lat);
        check("bp new latency", 128'(lat), 128'd4);
        check("bp new sum", sum, 128'd101);
        release_result();

        // Mid-run reset after two words have been written (idx=2).
        accept({128{1'b1}}, {128{1'b1}}, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst partial sum", sum, 128'h00000000_00000000_FFFFFFFF_FFFFFFFE);
        check("rst partial out_valid", 128'(out_valid), 128'd0);
        rst = 1'b1;
        #1;
        check("rst async out_valid", 128'(out_valid), 128'd0);
        check("rst async sum", sum, 128'd0);
        check("rst async cout", 128'(cout), 128'd0);
        check("rst async in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        accept(128'd3, 128'd4, 1'b0);
        wait_done(lat);
        check("after rst latency", 128'(lat), 128'd4);
        check("after rst sum", sum, 128'd7);
        check("after rst cout", 128'(cout), 128'd0);
        release_result();

        // WORDS=1 instance.
        a1 = 32'hFFFFFFFF;
        b1 = 32'hFFFFFFFF;
        sub1 = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("w1 run out_valid", 128'(out_valid1), 128'd0);
        @(posedge clk);
        @(negedge clk);
        check("w1 out_valid", 128'(out_valid1), 128'd1);
        check("w1 sum", 128'(sum1), 128'hFFFFFFFE);
        check("w1 cout", 128'(cout1), 128'd1);
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1 idle in_ready", 128'(in_ready1), 128'd1);
        a1 = 32'd0;
        b1 = 32'd1;
        sub1 = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w1 sub out_valid", 128'(out_valid1), 128'd1);
        check("w1 sub sum", 128'(sum1), 128'hFFFFFFFF);
        check("w1 sub cout", 128'(cout1), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
